// File: rtl/sum_accumulator.sv
// sum_accumulator: adds up a burst of N unsigned sum samples and
// presents the burst total with a valid/ready handshake.
module sum_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int OUT_W = WIDTH + CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_in_ready,
    input  logic [CNT_W-1:0] io_count,
    output logic             io_out_valid,
    output logic [OUT_W-1:0] io_out_bits,
    input  logic             io_out_ready,
    output logic             io_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [CNT_W:0]   cnt;
    logic [CNT_W:0]   target;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             in_fire;
    logic             out_fire;
    logic [CNT_W:0]   tgt_new;
    logic [CNT_W:0]   cnt_inc;
    logic [OUT_W-1:0] sample_ext;

    // A zero count field encodes the largest burst, 2^CNT_W samples.
    assign tgt_new    = (io_count == '0) ? CNT_MAX : {1'b0, io_count};
    assign cnt_inc    = cnt + CNT_ONE;
    assign sample_ext = OUT_W'(io_in_bits);
    assign in_fire    = io_in_valid && in_ready_q;
    assign out_fire   = out_valid_q && io_out_ready;

    assign io_in_ready  = in_ready_q;
    assign io_out_valid = out_valid_q;
    assign io_out_bits  = acc;
    assign io_busy      = busy_q;

    // Burst FSM; the handshake flags are registered next to the state
    // so they change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            target      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        target <= tgt_new;
                        acc    <= sample_ext;
                        cnt    <= CNT_ONE;
                        if (tgt_new == CNT_ONE) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state  <= ACCUM;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        acc <= acc + sample_ext;
                        cnt <= cnt_inc;
                        if (cnt_inc == target) begin
                            state       <= DONE;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: vector table, hand-written corner sequences and
// randomized bursts checked against a queue-based sum model.
module tb_sum_accumulator;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int OUT_W = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             io_in_valid;
    logic [WIDTH-1:0] io_in_bits;
    logic             io_in_ready;
    logic [CNT_W-1:0] io_count;
    logic             io_out_valid;
    logic [OUT_W-1:0] io_out_bits;
    logic             io_out_ready;
    logic             io_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sum_accumulator #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_bits  (io_in_bits),
        .io_in_ready (io_in_ready),
        .io_count    (io_count),
        .io_out_valid(io_out_valid),
        .io_out_bits (io_out_bits),
        .io_out_ready(io_out_ready),
        .io_busy     (io_busy)
    );

    typedef struct {
        logic [3:0]  count;
        int          n;
        logic [15:0] s [16];
        bit          gapped;
        int          exp_total;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] s);
        io_in_valid = 1'b1;
        io_in_bits  = s;
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " out_valid"}, io_out_valid, 0);
        chk({tag, " out_bits"}, io_out_bits, 0);
        chk({tag, " busy"}, io_busy, 0);
        chk({tag, " in_ready"}, io_in_ready, 1);
    endtask

    task automatic apply_vec(input int k);
        vec_t v;
        int   g;
        v = vecs[k];
        io_count = v.count;
        for (int i = 0; i < v.n; i++) begin
            g = v.gapped ? (i % 4) : 0;
            for (int j = 0; j < g; j++) begin
                io_in_valid = 1'b0;
                tick();
                chk($sformatf("v%0d gap busy", k), io_busy, (i > 0));
                chk($sformatf("v%0d gap oval", k), io_out_valid, 0);
            end
            chk($sformatf("v%0d ready s%0d", k, i), io_in_ready, 1);
            feed(v.s[i]);
            io_count = 4'($urandom);
            if (i < v.n - 1) begin
                chk($sformatf("v%0d busy s%0d", k, i), io_busy, 1);
                chk($sformatf("v%0d oval s%0d", k, i), io_out_valid, 0);
            end
        end
        chk($sformatf("v%0d done oval", k), io_out_valid, 1);
        chk($sformatf("v%0d total", k), io_out_bits, v.exp_total);
        chk($sformatf("v%0d done ready", k), io_in_ready, 0);
        chk($sformatf("v%0d done busy", k), io_busy, 0);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        chk($sformatf("v%0d idle oval", k), io_out_valid, 0);
        chk($sformatf("v%0d idle ready", k), io_in_ready, 1);
        chk($sformatf("v%0d kept total", k), io_out_bits, v.exp_total);
    endtask

    task automatic random_bursts(input int nb);
        logic [3:0]  c;
        int          n;
        int          g;
        int          hold;
        longint      total;
        logic [15:0] q [$];
        for (int b = 0; b < nb; b++) begin
            c = 4'($urandom);
            n = (c == 0) ? 16 : int'(c);
            q.delete();
            io_count = c;
            for (int i = 0; i < n; i++) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    io_in_valid = 1'b0;
                    tick();
                end
                q.push_back(16'($urandom));
                feed(q[$]);
                io_count = 4'($urandom);
            end
            total = 0;
            foreach (q[i]) total += longint'(q[i]);
            hold = $urandom_range(0, 3);
            io_in_valid = 1'b1;
            io_in_bits  = 16'($urandom);
            repeat (hold) begin
                chk($sformatf("r%0d hold total", b), io_out_bits, total[31:0]);
                chk($sformatf("r%0d hold ready", b), io_in_ready, 0);
                tick();
            end
            chk($sformatf("r%0d oval", b), io_out_valid, 1);
            chk($sformatf("r%0d total", b), io_out_bits, total[31:0]);
            io_in_valid  = 1'b0;
            io_out_ready = 1'b1;
            tick();
            io_out_ready = 1'b0;
            chk($sformatf("r%0d back idle", b), io_out_valid, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].count = 4'd2;
        vecs[0].n = 2;
        vecs[0].s[0] = 16'd10;
        vecs[0].s[1] = 16'd29;
        vecs[0].gapped = 1'b0;
        vecs[0].exp_total = 39;

        vecs[1].count = 4'd1;
        vecs[1].n = 1;
        vecs[1].s[0] = 16'd11;
        vecs[1].gapped = 1'b0;
        vecs[1].exp_total = 11;

        vecs[2].count = 4'd0;
        vecs[2].n = 16;
        for (int i = 0; i < 16; i++) vecs[2].s[i] = 16'hFFFF;
        vecs[2].gapped = 1'b1;
        vecs[2].exp_total = 1048560;

        vecs[3].count = 4'd3;
        vecs[3].n = 3;
        vecs[3].s[0] = 16'd100;
        vecs[3].s[1] = 16'd200;
        vecs[3].s[2] = 16'd300;
        vecs[3].gapped = 1'b1;
        vecs[3].exp_total = 600;

        vecs[4].count = 4'd5;
        vecs[4].n = 5;
        for (int i = 0; i < 5; i++) vecs[4].s[i] = 16'(i + 1);
        vecs[4].gapped = 1'b0;
        vecs[4].exp_total = 15;

        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_count     = '0;
        io_out_ready = 1'b0;
        #2;
        chk_idle_outs("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) apply_vec(k);

        // Result stalled by downstream; offered input must be ignored.
        io_count = 4'd2;
        feed(16'd3);
        feed(16'd4);
        io_in_valid = 1'b1;
        io_in_bits  = 16'd99;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall oval c%0d", i), io_out_valid, 1);
            chk($sformatf("stall bits c%0d", i), io_out_bits, 7);
            chk($sformatf("stall ready c%0d", i), io_in_ready, 0);
            tick();
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        chk("stall release oval", io_out_valid, 0);
        chk("stall release ready", io_in_ready, 1);
        chk("stall release bits", io_out_bits, 7);
        io_count = 4'd1;
        feed(16'd5);
        chk("after stall total", io_out_bits, 5);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;

        // Reset in the middle of a burst.
        io_count = 4'd4;
        feed(16'd1000);
        feed(16'd2000);
        chk("mid burst busy", io_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outs("async reset accum");
        @(negedge clk);
        reset = 1'b0;
        io_count = 4'd1;
        feed(16'd5);
        chk("post reset oval", io_out_valid, 1);
        chk("post reset total", io_out_bits, 5);

        // Reset while a total is pending.
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outs("async reset done");
        @(negedge clk);
        reset = 1'b0;

        random_bursts(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
